// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman systolic aligner.
// Holds parameter defaults, base encoding, FSM states and score width.
package sw_pkg;

    localparam int PE_N       = 8;
    localparam int PE_N_LOG   = 3;
    localparam int SRAM_DEPTH = 64;
    localparam int SCORE_W    = 16;
    localparam int WORD_BASES = 7;

    typedef enum logic [1:0] {
        BASE_A = 2'b00,
        BASE_C = 2'b01,
        BASE_G = 2'b10,
        BASE_T = 2'b11
    } base_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_T,
        REQ,
        RECV,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/sw_pe.sv
// One systolic cell: holds an S base, scores one T column per cycle.
// Left/diag state is kept locally, up values arrive from the cell above.
module sw_pe import sw_pkg::*; #(
    parameter int W = SCORE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    input  base_t        in_t,
    input  logic [W-1:0] in_h,
    input  logic [W-1:0] in_f,
    input  base_t        s_base,
    input  logic [3:0]   match,
    input  logic [3:0]   mismatch,
    input  logic [7:0]   alpha,
    input  logic [7:0]   beta,
    output logic         out_valid,
    output base_t        out_t,
    output logic [W-1:0] out_h,
    output logic [W-1:0] out_f
);

    logic [W-1:0] h_left;
    logic [W-1:0] e_left;
    logic [W-1:0] h_diag;
    logic [W-1:0] e;
    logic [W-1:0] f;
    logic [W-1:0] d;
    logic [W-1:0] h;

    function automatic logic [W-1:0] sub0(logic [W-1:0] a, logic [W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [W-1:0] max2(logic [W-1:0] a, logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Affine-gap cell scores, all clamped at zero
    always_comb begin
        e = max2(sub0(h_left, W'(alpha)), sub0(e_left, W'(beta)));
        f = max2(sub0(in_h, W'(alpha)), sub0(in_f, W'(beta)));
        d = (in_t == s_base) ? h_diag + W'(match)
                             : sub0(h_diag, W'(mismatch));
        h = max2(d, max2(e, f));
    end

    // Pass column results down and keep this row's left/diag history
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            out_valid <= 1'b0;
            out_t     <= BASE_A;
            out_h     <= '0;
            out_f     <= '0;
            h_left    <= '0;
            e_left    <= '0;
            h_diag    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_t  <= in_t;
                out_h  <= h;
                out_f  <= f;
                h_left <= h;
                e_left <= e;
                h_diag <= in_h;
            end
        end
    end

endmodule

// File: rtl/sw_top.sv
// Smith-Waterman local aligner: T buffer, chunked S, systolic PE row.
// The row buffer carries H/F of the last S row between chunks.
module sw_top import sw_pkg::*; #(
    parameter int PE_Array_size     = PE_N,
    parameter int PE_Array_size_log = PE_N_LOG,
    parameter int Sram_Addr         = SRAM_DEPTH,
    parameter int V_E_F_Bit         = SCORE_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_set_t,
    input  logic [17:0]                  i_t,
    input  logic                         i_param_valid,
    input  logic [3:0]                   i_match,
    input  logic [3:0]                   i_mismatch,
    input  logic [7:0]                   i_minusAlpha,
    input  logic [7:0]                   i_minusBeta,
    input  logic                         i_start_cal,
    output logic                         o_request_s,
    input  logic [PE_Array_size*2-1:0]   i_s,
    input  logic [PE_Array_size_log:0]   i_s_valid,
    output logic                         o_busy,
    output logic [V_E_F_Bit-1:0]         o_result,
    output logic                         o_valid
);

    localparam int N    = PE_Array_size;
    localparam int NL   = PE_Array_size_log;
    localparam int W    = V_E_F_Bit;
    localparam int AW   = $clog2(Sram_Addr);
    localparam int TMAX = WORD_BASES * Sram_Addr;
    localparam int RW   = $clog2(TMAX);
    localparam int LW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(TMAX + N + 1);

    state_t state;
    state_t state_nx;

    logic [13:0]   tbuf [Sram_Addr];
    logic [LW-1:0] t_len;
    logic [AW-1:0] wr_word;
    logic          last_word;

    logic [3:0] match_q;
    logic [3:0] mismatch_q;
    logic [7:0] alpha_q;
    logic [7:0] beta_q;

    logic [2*N-1:0] s_q;
    logic [NL:0]    s_cnt;
    logic [CW-1:0]  cyc;
    logic [AW-1:0]  rd_word;
    logic [2:0]     rd_base;
    logic           chunk_end;
    logic           last_chunk;

    logic [W-1:0]  rb_h [TMAX];
    logic [W-1:0]  rb_f [TMAX];
    logic          rb_valid;
    logic [RW-1:0] wcol;
    logic [NL-1:0] sel;
    logic          wr_en;

    logic [W-1:0] best;
    logic [W-1:0] best_nx;
    logic [W-1:0] result;

    logic [N-1:0] v_in;
    logic [N-1:0] v_out;
    base_t        t_in  [N];
    base_t        t_out [N];
    logic [W-1:0] h_in  [N];
    logic [W-1:0] f_in  [N];
    logic [W-1:0] h_out [N];
    logic [W-1:0] f_out [N];

    logic unused_bits;

    assign last_word   = i_t[16:14] != 3'd0;
    assign chunk_end   = cyc == CW'(t_len) + CW'(N - 1);
    assign last_chunk  = s_cnt != (NL + 1)'(N);
    assign sel         = NL'(s_cnt - 1'b1);
    assign wr_en       = rst_n && state == CALC && v_out[sel];
    assign o_result    = result;
    assign unused_bits = i_t[17] ^ (^{t_out[N-1]});

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; a T load wins over a calculation start
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (i_set_t)          state_nx = LOAD_T;
                else if (i_start_cal) state_nx = REQ;
            end
            LOAD_T: if (last_word) state_nx = IDLE;
            REQ:    state_nx = RECV;
            RECV:   state_nx = (i_s_valid == '0) ? DONE : CALC;
            CALC: begin
                if (chunk_end) state_nx = last_chunk ? DONE : REQ;
            end
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        o_busy      = 1'b0;
        o_request_s = 1'b0;
        o_valid     = 1'b0;
        unique case (state)
            LOAD_T, RECV, CALC: o_busy = 1'b1;
            REQ: begin
                o_busy      = 1'b1;
                o_request_s = 1'b1;
            end
            DONE:    o_valid = 1'b1;
            default: ;
        endcase
    end

    // T length tracking during a load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_len   <= '0;
            wr_word <= '0;
        end else if (state == IDLE && i_set_t) begin
            t_len   <= '0;
            wr_word <= '0;
        end else if (state == LOAD_T) begin
            wr_word <= wr_word + 1'b1;
            if (last_word)
                t_len <= LW'(wr_word) * LW'(WORD_BASES) + LW'(i_t[16:14]);
        end
    end

    // T word storage, one word per load cycle
    always_ff @(posedge clk) begin
        if (rst_n && state == LOAD_T) tbuf[wr_word] <= i_t[13:0];
    end

    // Scoring parameters, frozen while a calculation runs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_q    <= '0;
            mismatch_q <= '0;
            alpha_q    <= '0;
            beta_q     <= '0;
        end else if (i_param_valid && !(state inside {REQ, RECV, CALC})) begin
            match_q    <= i_match;
            mismatch_q <= i_mismatch;
            alpha_q    <= i_minusAlpha;
            beta_q     <= i_minusBeta;
        end
    end

    // Running maximum over PEs holding a real S base
    always_comb begin
        best_nx = best;
        if (state == CALC) begin
            for (int k = 0; k < N; k++) begin
                if (v_out[k] && k < int'(s_cnt) && h_out[k] > best_nx)
                    best_nx = h_out[k];
            end
        end
    end

    // Chunk sequencing, T streaming pointers, maximum and result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q      <= '0;
            s_cnt    <= '0;
            cyc      <= '0;
            rd_word  <= '0;
            rd_base  <= '0;
            wcol     <= '0;
            best     <= '0;
            rb_valid <= 1'b0;
            result   <= '0;
        end else begin
            if (state == IDLE && i_start_cal && !i_set_t) begin
                best     <= '0;
                rb_valid <= 1'b0;
            end
            if (state == RECV) begin
                s_q     <= i_s;
                s_cnt   <= i_s_valid;
                cyc     <= '0;
                rd_word <= '0;
                rd_base <= '0;
                wcol    <= '0;
            end
            if (state == CALC) begin
                cyc  <= cyc + 1'b1;
                best <= best_nx;
                if (rd_base == 3'd6) begin
                    rd_base <= '0;
                    rd_word <= rd_word + 1'b1;
                end else begin
                    rd_base <= rd_base + 1'b1;
                end
                if (wr_en)     wcol     <= wcol + 1'b1;
                if (chunk_end) rb_valid <= 1'b1;
            end
            if (state_nx == DONE) result <= best_nx;
        end
    end

    // Last valid PE row feeds the next chunk's top boundary
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rb_h[wcol] <= h_out[sel];
            rb_f[wcol] <= f_out[sel];
        end
    end

    assign v_in[0] = state == CALC && cyc < CW'(t_len);
    assign t_in[0] = base_t'(tbuf[rd_word][{rd_base, 1'b0} +: 2]);
    assign h_in[0] = (rb_valid && v_in[0]) ? rb_h[cyc[RW-1:0]] : '0;
    assign f_in[0] = (rb_valid && v_in[0]) ? rb_f[cyc[RW-1:0]] : '0;

    for (genvar k = 1; k < N; k++) begin : g_link
        assign v_in[k] = v_out[k-1];
        assign t_in[k] = t_out[k-1];
        assign h_in[k] = h_out[k-1];
        assign f_in[k] = f_out[k-1];
    end

    for (genvar k = 0; k < N; k++) begin : g_pe
        sw_pe #(.W(W)) u_pe (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (state == RECV),
            .in_valid (v_in[k]),
            .in_t     (t_in[k]),
            .in_h     (h_in[k]),
            .in_f     (f_in[k]),
            .s_base   (base_t'(s_q[2*k +: 2])),
            .match    (match_q),
            .mismatch (mismatch_q),
            .alpha    (alpha_q),
            .beta     (beta_q),
            .out_valid(v_out[k]),
            .out_t    (t_out[k]),
            .out_h    (h_out[k]),
            .out_f    (f_out[k])
        );
    end

endmodule

// File: tb/tb_sw_top.sv
// Randomized scoreboard bench for sw_top.
// Expected scores come from a full-matrix affine-gap local alignment.
module tb_sw_top;
    import sw_pkg::*;

    localparam int N = 8;

    typedef logic [1:0] bq_t[$];
    typedef struct {
        logic [2*N-1:0] s;
        logic [3:0]     n;
    } chunk_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_set_t;
    logic [17:0]   i_t;
    logic          i_param_valid;
    logic [3:0]    i_match;
    logic [3:0]    i_mismatch;
    logic [7:0]    i_minusAlpha;
    logic [7:0]    i_minusBeta;
    logic          i_start_cal;
    logic          o_request_s;
    logic [2*N-1:0] i_s;
    logic [3:0]    i_s_valid;
    logic          o_busy;
    logic [15:0]   o_result;
    logic          o_valid;

    chunk_t chunk_q[$];
    int     exp_q[$];
    int     req_q[$];
    int     tests = 0;
    int     fails = 0;
    int     reqs  = 0;
    bq_t    cur_t;
    int     pm, pmm, pa, pb;

    always #5 clk = ~clk;

    sw_top dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_set_t      (i_set_t),
        .i_t          (i_t),
        .i_param_valid(i_param_valid),
        .i_match      (i_match),
        .i_mismatch   (i_mismatch),
        .i_minusAlpha (i_minusAlpha),
        .i_minusBeta  (i_minusBeta),
        .i_start_cal  (i_start_cal),
        .o_request_s  (o_request_s),
        .i_s          (i_s),
        .i_s_valid    (i_s_valid),
        .o_busy       (o_busy),
        .o_result     (o_result),
        .o_valid      (o_valid)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bq_t str2b(string x);
        bq_t q;
        for (int i = 0; i < x.len(); i++) begin
            case (x[i])
                "A":     q.push_back(2'b00);
                "C":     q.push_back(2'b01);
                "G":     q.push_back(2'b10);
                default: q.push_back(2'b11);
            endcase
        end
        return q;
    endfunction

    // Textbook Gotoh local alignment over the whole S x T matrix
    function automatic int model(bq_t s, bq_t t, int m, int mm, int a, int b);
        int hp[$];
        int fp[$];
        int hc[$];
        int fc[$];
        int best;
        best = 0;
        for (int j = 0; j < t.size(); j++) begin
            hp.push_back(0);
            fp.push_back(0);
        end
        for (int i = 0; i < s.size(); i++) begin
            int hl;
            int el;
            hl = 0;
            el = 0;
            hc = {};
            fc = {};
            for (int j = 0; j < t.size(); j++) begin
                int dg, e, f, d, h;
                dg = (j == 0) ? 0 : hp[j-1];
                e  = imax(0, imax(hl - a, el - b));
                f  = imax(0, imax(hp[j] - a, fp[j] - b));
                d  = (s[i] == t[j]) ? dg + m : dg - mm;
                h  = imax(imax(0, d), imax(e, f));
                hc.push_back(h);
                fc.push_back(f);
                hl = h;
                el = e;
                best = imax(best, h);
            end
            hp = hc;
            fp = fc;
        end
        return best;
    endfunction

    task automatic set_params(input int m, input int mm, input int a, input int b);
        @(negedge clk);
        i_param_valid = 1'b1;
        i_match       = 4'(m);
        i_mismatch    = 4'(mm);
        i_minusAlpha  = 8'(a);
        i_minusBeta   = 8'(b);
        pm = m; pmm = mm; pa = a; pb = b;
        @(negedge clk);
        i_param_valid = 1'b0;
    endtask

    task automatic load_t(input bq_t t, input bit both);
        int n;
        int words;
        logic [17:0] word;
        n = t.size();
        words = (n + 6) / 7;
        @(negedge clk);
        i_set_t = 1'b1;
        i_start_cal = both;
        for (int w = 0; w < words; w++) begin
            @(negedge clk);
            i_set_t = 1'b0;
            i_start_cal = 1'b0;
            word = '0;
            for (int k = 0; k < 7; k++)
                if (w * 7 + k < n) word[2*k +: 2] = t[w*7+k];
            if (w == words - 1) word[16:14] = 3'(n - 7 * w);
            word[17] = 1'($urandom_range(0, 1));
            i_t = word;
            chk("busy_during_load", o_busy, 1);
        end
        @(negedge clk);
        i_t = '0;
        chk("busy_after_load", o_busy, 0);
        cur_t = t;
    endtask

    // expv < 0 asks the reference model for the score
    task automatic run_cal(input bq_t s, input int expv, input bit check);
        int pos;
        int nch;
        chunk_t c;
        pos = 0;
        nch = 0;
        do begin
            c.s = '0;
            c.n = (s.size() - pos >= N) ? 4'(N) : 4'(s.size() - pos);
            for (int k = 0; k < int'(c.n); k++) c.s[2*k +: 2] = s[pos+k];
            pos += int'(c.n);
            chunk_q.push_back(c);
            nch++;
        end while (c.n == 4'(N));
        if (check) begin
            exp_q.push_back(expv < 0 ? model(s, cur_t, pm, pmm, pa, pb) : expv);
            req_q.push_back(nch);
        end
        @(negedge clk);
        i_start_cal = 1'b1;
        @(negedge clk);
        i_start_cal = 1'b0;
        @(negedge clk);
        i_start_cal = 1'b1;
        @(negedge clk);
        i_start_cal = 1'b0;
        if (check) begin
            for (int cy = 0; cy < 3000 && exp_q.size() > 0; cy++) @(negedge clk);
            if (exp_q.size() > 0) begin
                chk("done_timeout", exp_q.size(), 0);
                exp_q.delete();
                req_q.delete();
            end
            chk("chunks_left", chunk_q.size(), 0);
            chunk_q.delete();
            repeat (2) @(negedge clk);
        end
    endtask

    // Chunk responder: answers each request for the following cycle
    initial begin : resp
        chunk_t c;
        forever begin
            @(negedge clk);
            if (rst_n && o_request_s) begin
                if (chunk_q.size() > 0) begin
                    c = chunk_q.pop_front();
                    i_s = c.s;
                    i_s_valid = c.n;
                end else begin
                    i_s = '0;
                    i_s_valid = '0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a result is presented
    initial begin : mon
        int e;
        int r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                reqs = 0;
            end else begin
                if (o_request_s) reqs++;
                if (o_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", o_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        r = req_q.pop_front();
                        chk("result", o_result, e);
                        chk("requests", reqs, r);
                        chk("busy_at_valid", o_busy, 0);
                    end
                    reqs = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        bq_t t;
        bq_t s;
        int tl;
        int sl;
        int off;
        rst_n = 1'b0;
        i_set_t = 1'b0;
        i_t = '0;
        i_param_valid = 1'b0;
        i_match = '0;
        i_mismatch = '0;
        i_minusAlpha = '0;
        i_minusBeta = '0;
        i_start_cal = 1'b0;
        i_s = '0;
        i_s_valid = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_request", o_request_s, 0);
        chk("rst_result", o_result, 0);
        rst_n = 1'b1;

        set_params(2, 1, 3, 1);
        load_t(str2b("ACGT"), 1'b0);
        run_cal(str2b("ACGT"), 8, 1'b1);
        run_cal(str2b("TTTT"), 2, 1'b1);

        set_params(2, 1, 2, 1);
        load_t(str2b("ACGTT"), 1'b0);
        run_cal(str2b("ACTT"), 6, 1'b1);

        set_params(2, 1, 3, 1);
        load_t(str2b("ACGTACGTACGTACGT"), 1'b0);
        run_cal(str2b("ACGTACGTACGTACGT"), 32, 1'b1);
        run_cal(s, 0, 1'b1);

        load_t(str2b("GATTACAGATTACA"), 1'b1);
        run_cal(str2b("TTACAG"), -1, 1'b1);

        for (int it = 0; it < 12; it++) begin
            set_params($urandom_range(1, 7), $urandom_range(0, 7),
                       $urandom_range(1, 9), $urandom_range(0, 4));
            tl = $urandom_range(1, 40);
            t = {};
            for (int k = 0; k < tl; k++) t.push_back(2'($urandom_range(0, 3)));
            load_t(t, 1'b0);
            sl = (it % 3 == 0) ? 8 * $urandom_range(0, 3) : $urandom_range(0, 24);
            off = $urandom_range(0, tl - 1);
            s = {};
            for (int k = 0; k < sl; k++) begin
                if ($urandom_range(0, 3) == 0) s.push_back(2'($urandom_range(0, 3)));
                else                           s.push_back(t[(off + k) % tl]);
            end
            run_cal(s, -1, 1'b1);
        end

        set_params(2, 1, 3, 1);
        load_t(str2b("ACGT"), 1'b0);
        run_cal(str2b("ACGT"), 8, 1'b0);
        repeat (2) @(negedge clk);
        chk("busy_before_reset", o_busy, 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_request", o_request_s, 0);
        chk("mid_rst_result", o_result, 0);
        rst_n = 1'b1;
        chunk_q.delete();
        repeat (30) @(negedge clk);
        set_params(2, 1, 3, 1);
        load_t(str2b("ACGT"), 1'b0);
        run_cal(str2b("ACGT"), 8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
